wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised write-back stage that merges results from `NUM_CH` producers (ALU/LSU/CSR pipeline, multiplier, divider, …) onto the single register-file write port. Each channel has a valid/ready handshake and its own small FIFO, so long-latency units can retire out of step with the in-order pipe. A registered arbiter (round-robin or fixed priority) drives the register-file write and the W-stage forwarding value. It replaces the fixed three-way result mux in the write-back stage.

## Interface
Parameters:
- `NUM_CH`, 3: number of producer channels, ≥1.
- `DEPTH`, 2: per-channel FIFO entries, power of two, ≥2.
- `DATA_W`, 32: result width.
- `ADDR_W`, 5: register address width.
- `RR_MODE`, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `ch_valid_i`  in  NUM_CH  per-channel result valid.
- `ch_ready_o`  out  NUM_CH  per-channel FIFO can accept.
- `ch_rd_addr_i`  in  NUM_CH×ADDR_W  destination register per channel.
- `ch_data_i`  in  NUM_CH×DATA_W  result data per channel.
- `regf_write_o`  out  1  register-file write enable.
- `regf_waddr_o`  out  ADDR_W  write address.
- `regf_wdata_o`  out  DATA_W  write data.
- `rdValueW_o`  out  DATA_W  forwarding value; equals `regf_wdata_o`.
- `grant_ch_o`  out  $clog2(NUM_CH) (min 1)  channel that sourced the current write.
- `idle_o`  out  1  all FIFOs empty and `regf_write_o` low.

## Operation
- Handshake: a beat is accepted on edge k when `ch_valid_i[i] & ch_ready_o[i]`. `ch_ready_o[i]` is `!full[i]` only. It does not depend on valid or on a same-cycle pop, so a full FIFO rejects a push even while it is being popped.
- A producer holds valid, addr and data stable until accepted. Dropping valid without a handshake is legal; nothing is enqueued.
- Order within a channel is FIFO. There is no ordering guarantee across channels. The issue logic never has the same rd in flight on two channels.
- Beats with `rd_addr == 0` are enqueued and arbitrated normally. When such a beat wins:
  - `regf_write_o` stays 0;
  - `regf_wdata_o`, `rdValueW_o` and `grant_ch_o` still update;
  - `regf_waddr_o` is 0.
- Arbitration runs each cycle over the non-empty FIFO heads:
  - Exactly one winner is popped per cycle; none if all FIFOs are empty.
  - Round-robin: the search starts at `last_grant+1` and wraps modulo NUM_CH. `last_grant` updates only on a grant.
  - Fixed priority: the lowest non-empty index wins.
- Output register: on a grant, the winner's data, address and channel load into the output register, and `regf_write_o` is set to `rd_addr != 0`. With no grant, `regf_write_o` goes to 0 and data/address/`grant_ch_o` hold their previous values.
- Reset (`rst_i` high at an edge), including mid-operation:
  - all FIFOs empty; entries in flight are discarded;
  - `last_grant` set to NUM_CH-1, so channel 0 is first;
  - `regf_write_o`, `regf_waddr_o`, `regf_wdata_o`, `rdValueW_o` and `grant_ch_o` set to 0;
  - `ch_ready_o` all 1 from the first cycle after reset;
  - `idle_o` = 1.

## Timing
- Latency: a beat accepted at edge k, into an empty FIFO with no competing heads, wins in cycle k+1. Its write is visible from edge k+1 to edge k+2.
- Throughput: one write per cycle sustained across all channels. A single channel sustains one per cycle if DEPTH≥2.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty use an extra wrap bit.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen and occupancy is unchanged. Push into an empty FIFO is not bypassed, so the beat is visible to the arbiter the next cycle.
- Fairness bound (round-robin): a non-empty head is granted within NUM_CH cycles.
- No combinational path from any `ch_valid_i` to `ch_ready_o` or to any `regf_*` output.

## Structure
- `riscv_pkg` gets `wb_req_t` (packed struct `{rd_addr, data}`) and `WB_NUM_CH`. Top-level ports stay flat.
- Sub-module `wb_fifo`: a synchronous FIFO with parameters DEPTH and a width, and ports push/pop/full/empty/head. It is instantiated NUM_CH times with a generate loop.
- Arbiter logic, `last_grant` and the output register are inline in `wb_arbiter`.

## Test plan
- **Reset mid-stream:** channel 1 holds 2 beats and `rst_i` is asserted for one edge → next cycle: all ready, `idle_o`=1, no writes ever appear for those beats.
- **Single beat:** channel 0 sends `{rd=5, data=0xDEADBEEF}` at edge 3 → `regf_write_o`=1, waddr=5, wdata = `rdValueW_o` = 0xDEADBEEF during edges 4–5, `grant_ch_o`=0, then `regf_write_o`=0.
- **Round-robin contention:** NUM_CH=3, all channels continuously valid with distinct data → grants 0,1,2,0,1,2…, one write per cycle, no channel starved.
- **Fixed priority:** RR_MODE=0, channels 0 and 2 both hold beats → all channel-0 beats drain first, then channel 2.
- **Backpressure:** DEPTH=2, channel 1 valid 4 beats while channels 0 and 2 are saturated and win → `ch_ready_o[1]` drops after 2 accepts; a push is refused on the full-and-popping cycle; all 4 beats are written in order.
- **x0 write:** a beat `{rd=0, data=0x1234}` wins → `regf_write_o`=0, `rdValueW_o`=0x1234, x0 is never written.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions used by the write-back result arbiter.
package riscv_pkg;

  localparam int WB_NUM_CH  = 3;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Index width for a select over n items; a single item still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for one write-back producer channel.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: per-producer FIFOs arbitrated onto the single register-file write port.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_CH  = WB_NUM_CH,
  parameter int DEPTH   = 2,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int RR_MODE = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  output logic [NUM_CH-1:0]            ch_ready_o,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_rd_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data_i,
  output logic                         regf_write_o,
  output logic [ADDR_W-1:0]            regf_waddr_o,
  output logic [DATA_W-1:0]            regf_wdata_o,
  output logic [DATA_W-1:0]            rdValueW_o,
  output logic [clog2_min1(NUM_CH)-1:0] grant_ch_o,
  output logic                         idle_o
);

  localparam int GW = clog2_min1(NUM_CH);
  localparam int EW = ADDR_W + DATA_W;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [EW-1:0]     head [NUM_CH];

  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     win;
  logic              grant;
  logic [EW-1:0]     win_entry;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
      ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (ch_valid_i[i]),
        .pop   (pop[i]),
        .din   ({ch_rd_addr_i[i*ADDR_W +: ADDR_W], ch_data_i[i*DATA_W +: DATA_W]}),
        .head  (head[i]),
        .full  (full[i]),
        .empty (empty[i])
      );
    end
  endgenerate

  // Ready reflects occupancy only, so valid never feeds back into ready.
  assign ch_ready_o = ~full;

  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    grant     = 1'b0;
    pop       = '0;
    win_entry = '0;
    if (RR_MODE != 0) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        idx = int'(last_grant) + off;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!grant && !empty[idx]) begin
          grant     = 1'b1;
          win       = GW'(idx);
          win_entry = head[idx];
          pop[idx]  = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant && !empty[i]) begin
          grant     = 1'b1;
          win       = GW'(i);
          win_entry = head[i];
          pop[i]    = 1'b1;
        end
      end
    end
  end

  assign win_addr = win_entry[EW-1:DATA_W];
  assign win_data = win_entry[DATA_W-1:0];

  // x0 results still travel through the forwarding path but never write the file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant   <= GW'(NUM_CH - 1);
      regf_write_o <= 1'b0;
      regf_waddr_o <= '0;
      regf_wdata_o <= '0;
      grant_ch_o   <= '0;
    end else begin
      regf_write_o <= 1'b0;
      if (grant) begin
        last_grant   <= win;
        grant_ch_o   <= win;
        regf_waddr_o <= win_addr;
        regf_wdata_o <= win_data;
        regf_write_o <= (win_addr != '0);
      end
    end
  end

  assign rdValueW_o = regf_wdata_o;
  assign idle_o     = (&empty) & ~regf_write_o;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: round-robin instance plus a fixed-priority instance.
module tb_wb_arbiter;

  localparam int NCH = 3;
  localparam int DEP = 2;
  localparam int AW  = 5;
  localparam int DW  = 32;

  typedef struct packed {
    logic [1:0]    ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]    ch_valid = '0;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*AW-1:0] ch_addr  = '0;
  logic [NCH*DW-1:0] ch_data  = '0;
  logic              regf_write;
  logic [AW-1:0]     regf_waddr;
  logic [DW-1:0]     regf_wdata;
  logic [DW-1:0]     rdv;
  logic [1:0]        grant_ch;
  logic              idle;

  logic [NCH-1:0]    fp_valid = '0;
  logic [NCH-1:0]    fp_ready;
  logic [NCH*AW-1:0] fp_addr  = '0;
  logic [NCH*DW-1:0] fp_data  = '0;
  logic              fp_write;
  logic [AW-1:0]     fp_waddr;
  logic [DW-1:0]     fp_wdata;
  logic [DW-1:0]     fp_rdv;
  logic [1:0]        fp_grant;
  logic              fp_idle;

  wb_arbiter #(.NUM_CH(NCH), .DEPTH(DEP), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
    .ch_rd_addr_i(ch_addr), .ch_data_i(ch_data),
    .regf_write_o(regf_write), .regf_waddr_o(regf_waddr), .regf_wdata_o(regf_wdata),
    .rdValueW_o(rdv), .grant_ch_o(grant_ch), .idle_o(idle)
  );

  wb_arbiter #(.NUM_CH(NCH), .DEPTH(DEP), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .ch_valid_i(fp_valid), .ch_ready_o(fp_ready),
    .ch_rd_addr_i(fp_addr), .ch_data_i(fp_data),
    .regf_write_o(fp_write), .regf_waddr_o(fp_waddr), .regf_wdata_o(fp_wdata),
    .rdValueW_o(fp_rdv), .grant_ch_o(fp_grant), .idle_o(fp_idle)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwrites = 0;
  bit chk_ready = 0;
  bit saw_full1 = 0;
  int occ [NCH];

  beat_t tx_q  [NCH][$];
  beat_t exp_q [NCH][$];
  beat_t fp_exp[$];
  int    gl_q[$];
  int    gc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int c, input int a, input logic [DW-1:0] d);
    beat_t b;
    b.ch   = 2'(c);
    b.addr = AW'(a);
    b.data = d;
    return b;
  endfunction

  // Scoreboard for the round-robin instance: pop the granted channel's oldest beat.
  always @(negedge clk) begin
    if (!rst && regf_write) begin
      beat_t b;
      nwrites++;
      gl_q.push_back(int'(grant_ch));
      gc_q.push_back(cyc);
      if (grant_ch >= 2'(NCH) || exp_q[grant_ch].size() == 0) begin
        chk("unexpected_write", 64'(grant_ch), 64'hFF);
      end else begin
        b = exp_q[grant_ch].pop_front();
        chk("waddr", 64'(regf_waddr), 64'(b.addr));
        chk("wdata", 64'(regf_wdata), 64'(b.data));
        chk("fwd_value", 64'(rdv), 64'(b.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && fp_write) begin
      beat_t b;
      if (fp_exp.size() == 0) begin
        chk("fp_unexpected_write", 64'(fp_grant), 64'hFF);
      end else begin
        b = fp_exp.pop_front();
        chk("fp_grant", 64'(fp_grant), 64'(b.ch));
        chk("fp_waddr", 64'(fp_waddr), 64'(b.addr));
        chk("fp_wdata", 64'(fp_wdata), 64'(b.data));
      end
    end
  end

  // Called just after a falling edge; drives one cycle of every producer.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      logic [NCH-1:0] acc;
      for (int c = 0; c < NCH; c++) begin
        if (tx_q[c].size() > 0) begin
          ch_valid[c]          = 1'b1;
          ch_addr[c*AW +: AW]  = tx_q[c][0].addr;
          ch_data[c*DW +: DW]  = tx_q[c][0].data;
        end else begin
          ch_valid[c] = 1'b0;
        end
      end
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (chk_ready) chk($sformatf("ready_ch%0d", c), 64'(ch_ready[c]), 64'(occ[c] < DEP));
      end
      if (ch_valid[1] && !ch_ready[1]) saw_full1 = 1;
      acc = ch_valid & ch_ready;
      @(posedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (acc[c]) begin
          beat_t b;
          b = tx_q[c].pop_front();
          occ[c]++;
          if (b.addr != '0) exp_q[c].push_back(b);
        end
      end
      @(negedge clk);
      #1;
      if (regf_write && grant_ch < 2'(NCH)) occ[grant_ch]--;
    end
  endtask

  task automatic do_reset();
    for (int c = 0; c < NCH; c++) tx_q[c].delete();
    ch_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      occ[c] = 0;
    end
  endtask

  initial begin
    int w0;
    for (int c = 0; c < NCH; c++) occ[c] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready", 64'(ch_ready), 64'h7);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_write", 64'(regf_write), 64'h0);
    chk("rst_waddr", 64'(regf_waddr), 64'h0);
    chk("rst_wdata", 64'(regf_wdata), 64'h0);
    chk("rst_fwd", 64'(rdv), 64'h0);
    chk("rst_grant", 64'(grant_ch), 64'h0);
    chk("rst_fp_ready", 64'(fp_ready), 64'h7);

    // Single beat: accepted at one edge, written for exactly the following cycle.
    tx_q[0].push_back(mk(0, 5, 32'hDEADBEEF));
    run_cycles(1);
    chk("single_no_bypass", 64'(regf_write), 64'h0);
    chk("single_idle_busy", 64'(idle), 64'h0);
    run_cycles(1);
    chk("single_write", 64'(regf_write), 64'h1);
    chk("single_grant", 64'(grant_ch), 64'h0);
    chk("single_waddr", 64'(regf_waddr), 64'h5);
    chk("single_fwd", 64'(rdv), 64'hDEADBEEF);
    run_cycles(1);
    chk("single_write_drop", 64'(regf_write), 64'h0);
    chk("single_idle", 64'(idle), 64'h1);
    chk("single_hold_data", 64'(regf_wdata), 64'hDEADBEEF);

    // x0 beat wins arbitration but never writes.
    tx_q[2].push_back(mk(2, 0, 32'h1234));
    run_cycles(2);
    chk("x0_write", 64'(regf_write), 64'h0);
    chk("x0_waddr", 64'(regf_waddr), 64'h0);
    chk("x0_wdata", 64'(regf_wdata), 64'h1234);
    chk("x0_fwd", 64'(rdv), 64'h1234);
    chk("x0_grant", 64'(grant_ch), 64'h2);
    run_cycles(1);
    chk("x0_idle", 64'(idle), 64'h1);

    // Reset while channel 1 holds two beats behind contention.
    for (int k = 0; k < 4; k++) begin
      tx_q[0].push_back(mk(0, 1 + k, 32'hA000_0000 + 32'(k)));
      tx_q[2].push_back(mk(2, 10 + k, 32'hC000_0000 + 32'(k)));
    end
    tx_q[1].push_back(mk(1, 20, 32'hB000_0000));
    tx_q[1].push_back(mk(1, 21, 32'hB000_0001));
    run_cycles(2);
    chk("mid_ch1_full", 64'(ch_ready[1]), 64'h0);
    do_reset();
    chk("mid_rst_ready", 64'(ch_ready), 64'h7);
    chk("mid_rst_idle", 64'(idle), 64'h1);
    w0 = nwrites;
    run_cycles(8);
    chk("mid_rst_no_writes", 64'(nwrites - w0), 64'h0);

    // Round-robin contention after reset: strict 0,1,2 rotation, one write per cycle.
    chk_ready = 1;
    gl_q.delete();
    gc_q.delete();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 6; k++)
        tx_q[c].push_back(mk(c, c*8 + k + 1, 32'hC0DE_0000 + 32'(c*256 + k)));
    run_cycles(24);
    chk("rr_write_count", 64'(gl_q.size()), 64'd18);
    for (int i = 0; i < gl_q.size(); i++) begin
      chk($sformatf("rr_grant_%0d", i), 64'(gl_q[i]), 64'(i % 3));
      if (i > 0) chk($sformatf("rr_back_to_back_%0d", i), 64'(gc_q[i] - gc_q[i-1]), 64'd1);
    end

    // Backpressure on channel 1 while neighbours stay saturated.
    saw_full1 = 0;
    for (int k = 0; k < 8; k++) begin
      tx_q[0].push_back(mk(0, 1 + k, 32'h0A00_0000 + 32'(k)));
      tx_q[2].push_back(mk(2, 11 + k, 32'h0C00_0000 + 32'(k)));
    end
    for (int k = 0; k < 4; k++) tx_q[1].push_back(mk(1, 25 + k, 32'h0B00_0000 + 32'(k)));
    run_cycles(32);
    chk("bp_ready_dropped", 64'(saw_full1), 64'h1);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("drained_tx_%0d", c), 64'(tx_q[c].size()), 64'h0);
      chk($sformatf("drained_exp_%0d", c), 64'(exp_q[c].size()), 64'h0);
    end
    chk("bp_idle", 64'(idle), 64'h1);
    chk_ready = 0;

    // Fixed priority: channel 0 drains fully before channel 2.
    fp_exp.push_back(mk(0, 6, 32'hAAAA_0000));
    fp_exp.push_back(mk(0, 8, 32'hAAAA_0001));
    fp_exp.push_back(mk(2, 7, 32'hCCCC_0000));
    fp_exp.push_back(mk(2, 9, 32'hCCCC_0001));
    fp_valid = 3'b101;
    fp_addr  = {5'd7, 5'd0, 5'd6};
    fp_data  = {32'hCCCC_0000, 32'h0, 32'hAAAA_0000};
    chk("fp_ready_a", 64'(fp_ready), 64'h7);
    @(posedge clk);
    @(negedge clk);
    #1;
    fp_addr = {5'd9, 5'd0, 5'd8};
    fp_data = {32'hCCCC_0001, 32'h0, 32'hAAAA_0001};
    chk("fp_ready_b", 64'(fp_ready), 64'h7);
    @(posedge clk);
    @(negedge clk);
    #1;
    fp_valid = '0;
    chk("fp_ready_c", 64'(fp_ready), 64'h3);
    repeat (6) @(negedge clk);
    #1;
    chk("fp_all_written", 64'(fp_exp.size()), 64'h0);
    chk("fp_idle", 64'(fp_idle), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
